lcd_text_writer: RTL and testbench

Initiator side of the LCD character handshake (`lcd_command`/`lcd_response` with `lcd_x`, `lcd_y`, `lcd_ascii`).

- Holds a 2x16 character shadow buffer written by the host at any rate.
- Tracks which cells have changed.
- Pushes only changed cells to the LCD controller, one four-phase handshake per character.
- Sits between the host logic and the LCD controller, so the host never blocks on the slow LCD.

---
 rtl/lcd_text_writer.sv | 144 ++++++++++++++
 tb/tb_lcd_text_writer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/lcd_text_writer.sv
// Host-side 2x16 character shadow buffer that forwards only changed cells to the
// LCD controller over a four-phase lcd_command/lcd_response handshake.

module lcd_text_cell #(
  parameter logic [7:0] CLEAR_CHAR = 8'h20
) (
  input  logic       clock_12_5m,
  input  logic       reset_12_5m,
  input  logic       wr_hit,
  input  logic [7:0] wr_ascii,
  input  logic       clear,
  input  logic       clr_dirty,
  output logic [7:0] value,
  output logic       dirty,
  output logic       chg
);

  // clear wins over a same-cycle write; only real value changes mark the cell
  always_comb chg = clear ? (value != CLEAR_CHAR) : (wr_hit && (wr_ascii != value));

  // a change in the same cycle as the clear request keeps the cell dirty
  always_ff @(posedge clock_12_5m) begin
    if (reset_12_5m) begin
      value <= CLEAR_CHAR;
      dirty <= 1'b0;
    end else begin
      if (chg) value <= clear ? CLEAR_CHAR : wr_ascii;
      dirty <= (dirty & ~clr_dirty) | chg;
    end
  end

endmodule

module lcd_text_writer #(
  parameter logic [7:0] CLEAR_CHAR = 8'h20
) (
  input  logic       clock_12_5m,
  input  logic       reset_12_5m,
  input  logic       wr_en,
  input  logic [3:0] wr_x,
  input  logic       wr_y,
  input  logic [7:0] wr_ascii,
  input  logic       clear,
  output logic       busy,
  output logic       lcd_command,
  input  logic       lcd_response,
  output logic [3:0] lcd_x,
  output logic       lcd_y,
  output logic [7:0] lcd_ascii
);

  localparam int NUM_CELLS = 32;

  localparam logic [1:0] S_SCAN = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_REL  = 2'd2;

  logic [1:0]                 state;
  logic [4:0]                 ptr, cur_idx, wr_idx, tgt_idx;
  logic                       pending;
  logic [NUM_CELLS-1:0][7:0]  cell_q;
  logic [NUM_CELLS-1:0]       dirty, chg, clr_dirty;
  logic                       dispatch, rel_done, hit;

  assign wr_idx   = {wr_y, wr_x};
  assign dispatch = (state == S_SCAN) && dirty[ptr] && !lcd_response;
  assign rel_done = (state == S_REL) && !lcd_response;

  // the cell in flight is ptr on the dispatch edge and cur_idx afterwards
  assign tgt_idx = (state == S_SCAN) ? ptr : cur_idx;
  assign hit     = chg[tgt_idx] && (dispatch || (state != S_SCAN));

  always_comb begin
    clr_dirty = '0;
    if (rel_done && !pending) clr_dirty[cur_idx] = 1'b1;
  end

  genvar i;
  generate
    for (i = 0; i < NUM_CELLS; i++) begin : g_cell
      lcd_text_cell #(.CLEAR_CHAR(CLEAR_CHAR)) u_cell (
        .clock_12_5m (clock_12_5m),
        .reset_12_5m (reset_12_5m),
        .wr_hit      (wr_en && (wr_idx == 5'(i))),
        .wr_ascii    (wr_ascii),
        .clear       (clear),
        .clr_dirty   (clr_dirty[i]),
        .value       (cell_q[i]),
        .dirty       (dirty[i]),
        .chg         (chg[i])
      );
    end
  endgenerate

  always_ff @(posedge clock_12_5m) begin
    if (reset_12_5m) begin
      state       <= S_SCAN;
      ptr         <= '0;
      cur_idx     <= '0;
      pending     <= 1'b0;
      lcd_command <= 1'b0;
      lcd_x       <= '0;
      lcd_y       <= 1'b0;
      lcd_ascii   <= CLEAR_CHAR;
    end else begin
      case (state)
        S_SCAN: begin
          if (dispatch) begin
            cur_idx     <= ptr;
            lcd_x       <= ptr[3:0];
            lcd_y       <= ptr[4];
            lcd_ascii   <= cell_q[ptr];
            lcd_command <= 1'b1;
            pending     <= hit;
            state       <= S_REQ;
          end else begin
            ptr <= ptr + 5'd1;
          end
        end
        S_REQ: begin
          if (hit) pending <= 1'b1;
          if (lcd_response) begin
            lcd_command <= 1'b0;
            state       <= S_REL;
          end
        end
        S_REL: begin
          if (hit) pending <= 1'b1;
          if (!lcd_response) begin
            ptr   <= cur_idx + 5'd1;
            state <= S_SCAN;
          end
        end
        default: begin
          lcd_command <= 1'b0;
          state       <= S_SCAN;
        end
      endcase
    end
  end

  assign busy = (|dirty) | (state != S_SCAN);

endmodule

// File: tb/tb_lcd_text_writer.sv
// Directed bench for lcd_text_writer with a slow four-phase responder and a
// shadow screen built from the characters the responder accepts.

module tb_lcd_text_writer;

  logic       clock_12_5m = 1'b0;
  logic       reset_12_5m = 1'b1;
  logic       wr_en = 1'b0;
  logic [3:0] wr_x = '0;
  logic       wr_y = 1'b0;
  logic [7:0] wr_ascii = '0;
  logic       clear = 1'b0;
  logic       busy;
  logic       lcd_command;
  logic       lcd_response = 1'b0;
  logic [3:0] lcd_x;
  logic       lcd_y;
  logic [7:0] lcd_ascii;

  int checks = 0;
  int errors = 0;

  lcd_text_writer #(.CLEAR_CHAR(8'h20)) dut (
    .clock_12_5m  (clock_12_5m),
    .reset_12_5m  (reset_12_5m),
    .wr_en        (wr_en),
    .wr_x         (wr_x),
    .wr_y         (wr_y),
    .wr_ascii     (wr_ascii),
    .clear        (clear),
    .busy         (busy),
    .lcd_command  (lcd_command),
    .lcd_response (lcd_response),
    .lcd_x        (lcd_x),
    .lcd_y        (lcd_y),
    .lcd_ascii    (lcd_ascii)
  );

  always #40 clock_12_5m = ~clock_12_5m;

  // responder: ack 20 cycles after command rises, release 20 cycles after it falls
  int         rcnt = 0;
  int         n_xfer = 0;
  logic [7:0] shadow [0:31];
  logic [7:0] log_a  [0:127];
  logic [4:0] log_i  [0:127];

  initial for (int k = 0; k < 32; k++) shadow[k] = 8'h20;

  always @(posedge clock_12_5m) begin
    if (!lcd_response) begin
      if (lcd_command) begin
        if (rcnt == 19) begin
          lcd_response <= 1'b1;
          rcnt <= 0;
          shadow[{lcd_y, lcd_x}] <= lcd_ascii;
          log_a[n_xfer[6:0]] <= lcd_ascii;
          log_i[n_xfer[6:0]] <= {lcd_y, lcd_x};
          n_xfer <= n_xfer + 1;
        end else rcnt <= rcnt + 1;
      end else rcnt <= 0;
    end else begin
      if (!lcd_command) begin
        if (rcnt == 19) begin
          lcd_response <= 1'b0;
          rcnt <= 0;
        end else rcnt <= rcnt + 1;
      end else rcnt <= 0;
    end
  end

  // protocol monitor sampled away from the active edge
  logic       prev_cmd = 1'b0, prev_rsp = 1'b0;
  logic [12:0] prev_out = '0;
  int proto_err = 0, stab_err = 0, busy_err = 0, cmd_rises = 0;

  always @(negedge clock_12_5m) begin
    prev_cmd <= lcd_command;
    prev_rsp <= lcd_response;
    prev_out <= {lcd_y, lcd_x, lcd_ascii};
    if (!reset_12_5m) begin
      if (lcd_command && !prev_cmd) cmd_rises <= cmd_rises + 1;
      if (lcd_command && !prev_cmd && (lcd_response || prev_rsp)) proto_err <= proto_err + 1;
      else if (!lcd_command && prev_cmd && !prev_rsp) proto_err <= proto_err + 1;
      if ((lcd_command || lcd_response) && (prev_cmd || prev_rsp) &&
          ({lcd_y, lcd_x, lcd_ascii} != prev_out)) stab_err <= stab_err + 1;
      if (!busy && (lcd_command || lcd_response)) busy_err <= busy_err + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int idx, input logic [7:0] c);
    wr_en = 1'b1; wr_x = 4'(idx); wr_y = idx[4]; wr_ascii = c;
    @(negedge clock_12_5m);
    wr_en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock_12_5m);
  endtask

  task automatic wait_idle(input string tag, input int max);
    int n = 0;
    while ((busy || lcd_command || lcd_response) && n < max) begin
      @(negedge clock_12_5m); n++;
    end
    chk(tag, 32'(n < max), 32'd1);
  endtask

  task automatic wait_cmd(input string tag);
    int n = 0;
    while (!lcd_command && n < 200) begin
      @(negedge clock_12_5m); n++;
    end
    chk(tag, 32'(lcd_command), 32'd1);
  endtask

  int bad, r0;

  initial begin
    // 1: reset values, then idle
    idle(3);
    reset_12_5m = 1'b0;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cmd", 32'(lcd_command), 0);
    chk("rst_ascii", 32'(lcd_ascii), 32'h20);
    chk("rst_xy", 32'({lcd_y, lcd_x}), 0);
    idle(100);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_no_cmd", cmd_rises, 0);

    // 2: single changed cell
    wr(19, 8'h41);
    chk("wr_busy", 32'(busy), 1);
    wait_idle("t2_done", 2000);
    chk("t2_xfers", n_xfer, 1);
    chk("t2_idx", 32'(log_i[0]), 32'd19);
    chk("t2_ascii", 32'(log_a[0]), 32'h41);
    chk("t2_shadow", 32'(shadow[19]), 32'h41);

    // 3: equal value is not resent
    wr(19, 8'h41);
    chk("t3_busy", 32'(busy), 0);
    idle(100);
    chk("t3_xfers", n_xfer, 1);

    // 4: overwrite while in flight forces a resend
    wr(5, 8'h42);
    wait_cmd("t4_cmd");
    wr(5, 8'h43);
    wait_idle("t4_done", 2000);
    chk("t4_xfers", n_xfer, 3);
    chk("t4_first", 32'({log_i[1], log_a[1]}), 32'({5'd5, 8'h42}));
    chk("t4_second", 32'({log_i[2], log_a[2]}), 32'({5'd5, 8'h43}));
    chk("t4_busy", 32'(busy), 0);

    // 5: fill the screen, then clear with a colliding write
    for (int i = 0; i < 32; i++) wr(i, 8'h30 + 8'(i % 10));
    wait_idle("t5_fill_done", 10000);
    bad = 0;
    for (int i = 0; i < 32; i++) if (shadow[i] !== 8'h30 + 8'(i % 10)) bad++;
    chk("t5_fill_screen", bad, 0);
    chk("t5_fill_xfers", n_xfer, 35);
    clear = 1'b1; wr(7, 8'h5a); clear = 1'b0;
    wait_idle("t5_clr_done", 10000);
    bad = 0;
    for (int i = 0; i < 32; i++) if (shadow[i] !== 8'h20) bad++;
    chk("t5_clr_screen", bad, 0);
    chk("t5_clr_drop_wr", 32'(shadow[7]), 32'h20);
    chk("t5_clr_xfers", n_xfer, 67);

    // 6: reset while a request is outstanding
    wr(10, 8'h51);
    wait_cmd("t6_cmd");
    reset_12_5m = 1'b1;
    @(negedge clock_12_5m);
    chk("t6_cmd_drop", 32'(lcd_command), 0);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_ascii", 32'(lcd_ascii), 32'h20);
    @(negedge clock_12_5m);
    reset_12_5m = 1'b0;
    r0 = cmd_rises;
    idle(100);
    chk("t6_no_req", cmd_rises, r0);
    chk("t6_xfers", n_xfer, 67);
    chk("t6_idle_busy", 32'(busy), 0);

    chk("proto", proto_err, 0);
    chk("stable", stab_err, 0);
    chk("busy_mon", busy_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
